// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path.
//   state_t  : main sequencer state, 4-bit encoding
//   Op*      : instr[6:0] opcodes the sequencer recognises
//   Res*     : resultsrc mux encodings
//   SrcA*    : alusrca mux encodings
//   SrcB*    : alusrcb mux encodings
//   Alu*     : aluop encodings consumed by the external ALU decoder
package control_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StExecU,
    StAluWb,
    StBranch,
    StJal,
    StIllegal
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // resultsrc
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // alusrca
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  // alusrcb
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // aluop
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // State that follows DECODE for a given opcode.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    unique case (op)
      OpLoad, OpStore: nxt = StMemAdr;
      OpRtype:         nxt = StExecR;
      OpItype:         nxt = StExecI;
      OpLui:           nxt = StExecU;
      OpBranch:        nxt = StBranch;
      OpJal:           nxt = StJal;
      default:         nxt = StIllegal;
    endcase
    return nxt;
  endfunction

  // funct3[0] distinguishes BNE (take on not-zero) from BEQ (take on zero).
  function automatic logic branch_taken(input logic is_bne, input logic zero);
    return is_bne ? ~zero : zero;
  endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multicycle RV32I core. Sequences the shared ALU, the single
// memory port, IR/PC and the register file, one state per cycle.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   op         in   instr[6:0] from IR
//   funct3     in   instr[14:12]; bit 0 selects BNE vs BEQ
//   zero       in   ALU result == 0
//   mem_ready  in   memory accepts/returns this cycle
//   mem_req    out  memory access request, held until mem_ready
//   adrsrc     out  memory address select: 0=PC, 1=ALUOut
//   memwrite   out  store strobe, only asserted together with mem_req
//   irwrite    out  IR load
//   pcwrite    out  PC load
//   regwrite   out  rd write
//   resultsrc  out  00=ALUOut 01=Data 10=ALUResult
//   alusrca    out  00=PC 01=OldPC 10=rs1 11=zero
//   alusrcb    out  00=rs2 01=ImmExt 10=const 4
//   aluop      out  00=add 01=sub 10=funct-decoded
//   retire     out  one-cycle pulse on the last cycle of each instruction
//   illegal    out  sticky flag: unsupported opcode seen (held until reset)
module multicycle_sequencer
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       retire,
  output logic       illegal
);

  state_t state_q, state_d;

  // Only funct3[0] matters to the sequencer; the rest goes to the ALU decoder.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  // Outputs are decoded from state_q, so an asynchronous reset drops every strobe
  // in the same cycle and no partially-sequenced write can complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:    state_d = StFetch;
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode:   state_d = decode_next(op);
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR,
      StExecI,
      StExecU:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StReset;
    endcase
  end

  // Output decode: Moore, except for the mem_ready/zero qualified strobes.
  always_comb begin
    mem_req   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = ResAluOut;
    alusrca   = SrcAPc;
    alusrcb   = SrcBRs2;
    aluop     = AluAdd;
    retire    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StReset: begin
      end
      StFetch: begin
        // ALU computes PC+4 while the instruction is read; PC and IR load together.
        mem_req   = 1'b1;
        adrsrc    = 1'b0;
        alusrca   = SrcAPc;
        alusrcb   = SrcBFour;
        aluop     = AluAdd;
        resultsrc = ResAluResult;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      StDecode: begin
        // Speculative branch/jal target OldPC+imm lands in ALUOut.
        alusrca = SrcAOldPc;
        alusrcb = SrcBImm;
        aluop   = AluAdd;
      end
      StMemAdr: begin
        alusrca = SrcARs1;
        alusrcb = SrcBImm;
        aluop   = AluAdd;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      StMemWb: begin
        resultsrc = ResData;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
      end
      StExecR: begin
        alusrca = SrcARs1;
        alusrcb = SrcBRs2;
        aluop   = AluFunct;
      end
      StExecI: begin
        alusrca = SrcARs1;
        alusrcb = SrcBImm;
        aluop   = AluFunct;
      end
      StExecU: begin
        // LUI: 0 + ImmExt
        alusrca = SrcAZero;
        alusrcb = SrcBImm;
        aluop   = AluAdd;
      end
      StAluWb: begin
        resultsrc = ResAluOut;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      StBranch: begin
        alusrca   = SrcARs1;
        alusrcb   = SrcBRs2;
        aluop     = AluSub;
        resultsrc = ResAluOut;
        pcwrite   = branch_taken(funct3[0], zero);
        retire    = 1'b1;
      end
      StJal: begin
        // PC <= ALUOut (target from DECODE) while the ALU forms the link value OldPC+4.
        alusrca   = SrcAOldPc;
        alusrcb   = SrcBFour;
        aluop     = AluAdd;
        resultsrc = ResAluOut;
        pcwrite   = 1'b1;
      end
      StIllegal: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
